// File: rtl/lfsr_stream_gen.sv
// Parametrised Galois LFSR pattern source with optional de Bruijn extension and an
// independent LSB-first snapshot serializer. Define LFSR_PERIOD_CHECK_EN to add period_wrap.
module lfsr_stream_gen #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'h1D),
    parameter bit               EXTEND       = 1'b1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(8'h01)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             out_enable,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lfsr_state,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    output logic             period_wrap
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SERIAL = 1'b1
    } ser_state_e;

    // ------------------------------------------------------------------
    // LFSR core
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] step_n;
    logic             fb;

    // The extension term flips feedback when only the MSB (or nothing) is set,
    // splicing the all-zero state between 10..0 and the tap pattern.
    always_comb begin
        fb = lfsr_q[WIDTH-1];
        if (EXTEND) begin
            fb = fb ^ ~|lfsr_q[WIDTH-2:0];
        end
        step_n[0] = fb;
        for (int i = 1; i < WIDTH; i++) begin
            step_n[i] = lfsr_q[i-1] ^ (TAPS[i] & fb);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = seed;
        end else if (enable) begin
            lfsr_d = step_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

    // ------------------------------------------------------------------
    // Snapshot serializer
    // Handshake: a bit moves on every rising edge where out_valid & out_ready;
    // while out_valid is high and out_ready low, out_bit/out_last are held stable,
    // and out_valid never drops without a transfer (except on reset).
    // ------------------------------------------------------------------
    ser_state_e       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Snapshot is the pre-edge LFSR value, independent of seed/step this edge.
                    if (out_enable) begin
                        shreg_q <= lfsr_q;
                        cnt_q   <= '0;
                        state_q <= S_SERIAL;
                        busy_q  <= 1'b1;
                    end
                end
                S_SERIAL: begin
                    if (out_ready) begin
                        shreg_q <= shreg_q >> 1;
                        if (last_bit) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = (state_q == S_SERIAL);
    assign out_bit   = out_valid & shreg_q[0];
    assign out_last  = out_valid & last_bit;
    assign busy      = busy_q;

`ifdef LFSR_PERIOD_CHECK_EN
    // ------------------------------------------------------------------
    // Period monitor: flags a step that lands back on the last loaded seed
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ref_q;
    logic             wrap_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ref_q  <= SEED_DEFAULT;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (seed_load) begin
                ref_q <= seed;
            end else if (enable && (step_n == ref_q)) begin
                wrap_q <= 1'b1;
            end
        end
    end

    assign period_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Self-checking bench for lfsr_stream_gen: vector table, hand-written serializer
// corner cases and a randomized run against a queue-based reference model.
module tb_lfsr_stream_gen;

    localparam int         WIDTH  = 8;
    localparam logic [7:0] TAPS_V = 8'h1D;
    localparam logic [7:0] SEED_D = 8'h01;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       enable = 1'b0;
    logic       out_enable = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] lfsr_state, p_state;
    logic       out_bit, out_valid, out_last, busy;
    logic       p_bit, p_valid, p_last, p_busy;
`ifdef LFSR_PERIOD_CHECK_EN
    logic       period_wrap, p_wrap;
`endif

    always #5 clock = ~clock;

    lfsr_stream_gen #(.WIDTH(WIDTH), .TAPS(TAPS_V), .EXTEND(1'b1), .SEED_DEFAULT(SEED_D)) dut (
        .clock(clock), .reset(reset), .seed_load(seed_load), .seed(seed), .enable(enable),
        .out_enable(out_enable), .out_ready(out_ready), .lfsr_state(lfsr_state),
        .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy)
`ifdef LFSR_PERIOD_CHECK_EN
        , .period_wrap(period_wrap)
`endif
    );

    lfsr_stream_gen #(.WIDTH(WIDTH), .TAPS(TAPS_V), .EXTEND(1'b0), .SEED_DEFAULT(SEED_D)) dut_plain (
        .clock(clock), .reset(reset), .seed_load(seed_load), .seed(seed), .enable(enable),
        .out_enable(out_enable), .out_ready(out_ready), .lfsr_state(p_state),
        .out_bit(p_bit), .out_valid(p_valid), .out_last(p_last), .busy(p_busy)
`ifdef LFSR_PERIOD_CHECK_EN
        , .period_wrap(p_wrap)
`endif
    );

    // ---------------- scoreboard ----------------
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiply-by-x modulo the tap polynomial, with the zero-state splice when ext is set.
    function automatic logic [7:0] ref_step(input logic [7:0] s, input bit ext);
        logic f;
        f = s[7] ^ (ext && (s[6:0] == 7'd0));
        return {s[6:0], 1'b0} ^ (f ? (TAPS_V | 8'h01) : 8'h00);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back(w[k]);
    endtask

    typedef struct {
        logic       sl;
        logic [7:0] sd;
        logic       en;
        logic [7:0] exp_ext;
        logic [7:0] exp_plain;
    } vec_t;

    vec_t vecs[16];

    logic [7:0] model_l;
    logic [0:0] b;
    int         xfers;
    int         first_ret;
    int         distinct;
    int         wraps;
    bit         seen[256];

    initial begin
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 8'h01, 8'h01};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h02, 8'h02};
        vecs[2]  = '{1'b1, 8'h80, 1'b0, 8'h80, 8'h80};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h1D};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h1D, 8'h3A};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h3A, 8'h74};
        vecs[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h1D, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h3A, 8'h00};
        vecs[9]  = '{1'b1, 8'h5A, 1'b1, 8'h5A, 8'h5A};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h5A, 8'h5A};
        vecs[11] = '{1'b1, 8'h01, 1'b0, 8'h01, 8'h01};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h02, 8'h02};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h04, 8'h04};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h08, 8'h08};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h08, 8'h08};

        // ---- reset state ----
        tick();
        check("rst_state", lfsr_state, SEED_D);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bit", out_bit, 0);
        check("rst_last", out_last, 0);
        reset = 1'b1;
        tick();

        // ---- step / priority vectors ----
        for (int i = 0; i < 16; i++) begin
            seed_load = vecs[i].sl;
            seed      = vecs[i].sd;
            enable    = vecs[i].en;
            tick();
            check($sformatf("vec%0d_ext", i), lfsr_state, vecs[i].exp_ext);
            check($sformatf("vec%0d_plain", i), p_state, vecs[i].exp_plain);
        end
        seed_load = 1'b0;
        enable    = 1'b0;

        // ---- full period with extension ----
        seed_load = 1'b1; seed = 8'h01;
        tick();
        seed_load = 1'b0; enable = 1'b1;
        first_ret = 0; distinct = 0; wraps = 0;
        for (int s = 1; s <= 300; s++) begin
            tick();
            if (!seen[lfsr_state]) begin
                seen[lfsr_state] = 1'b1;
                distinct++;
            end
`ifdef LFSR_PERIOD_CHECK_EN
            if (period_wrap) wraps++;
`endif
            if (lfsr_state == 8'h01) begin
                first_ret = s;
                break;
            end
        end
        enable = 1'b0;
        tick();
`ifdef LFSR_PERIOD_CHECK_EN
        if (period_wrap) wraps++;
        check("period_wrap_pulses", wraps, 1);
`endif
        check("period_len", first_ret, 256);
        check("period_distinct", distinct, 256);

        // ---- serializer, free-flowing, LFSR stepping ----
        seed_load = 1'b1; seed = 8'hA5;
        tick();
        seed_load = 1'b0; out_enable = 1'b1; enable = 1'b1; out_ready = 1'b1;
        check("ser_latency_valid", out_valid, 0);
        tick();
        out_enable = 1'b0;
        push_word(8'hA5);
        model_l = ref_step(8'hA5, 1'b1);
        for (int k = 0; k < WIDTH; k++) begin
            check($sformatf("ser_valid%0d", k), out_valid, 1);
            check($sformatf("ser_busy%0d", k), busy, 1);
            check($sformatf("ser_last%0d", k), out_last, (k == WIDTH - 1));
            check($sformatf("ser_lfsr%0d", k), lfsr_state, model_l);
            b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("ser_bit%0d", k), out_bit, b);
            model_l = ref_step(model_l, 1'b1);
            tick();
        end
        check("ser_done_valid", out_valid, 0);
        check("ser_done_busy", busy, 0);
        enable = 1'b0;

        // ---- backpressure and ignored mid-word request ----
        seed_load = 1'b1; seed = 8'hA5;
        tick();
        seed_load = 1'b0; out_enable = 1'b1;
        tick();
        out_enable = 1'b0;
        exp_q.delete();
        push_word(8'hA5);
        xfers = 0;
        for (int c = 1; c <= 20 && xfers < WIDTH; c++) begin
            out_ready  = !(c >= 3 && c <= 5);
            out_enable = (c == 4);
            if (c >= 3 && c <= 5) begin
                check($sformatf("bp_hold_bit_c%0d", c), out_bit, 1);
                check($sformatf("bp_busy_c%0d", c), busy, 1);
            end
            if (out_valid && out_ready) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("bp_bit%0d", xfers), out_bit, b);
                check($sformatf("bp_last%0d", xfers), out_last, (xfers == WIDTH - 1));
                xfers++;
            end
            tick();
        end
        out_enable = 1'b0; out_ready = 1'b1;
        check("bp_xfers", xfers, WIDTH);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_no_second%0d", k), out_valid, 0);
            tick();
        end

        // ---- reset mid-word ----
        seed_load = 1'b1; seed = 8'hA5;
        tick();
        seed_load = 1'b0; out_enable = 1'b1; enable = 1'b1;
        tick();
        out_enable = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", lfsr_state, SEED_D);
        tick();
        reset = 1'b1; enable = 1'b0; out_enable = 1'b1;
        tick();
        out_enable = 1'b0;
        exp_q.delete();
        push_word(SEED_D);
        for (int k = 0; k < WIDTH; k++) begin
            check($sformatf("fresh_valid%0d", k), out_valid, 1);
            check($sformatf("fresh_last%0d", k), out_last, (k == WIDTH - 1));
            b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("fresh_bit%0d", k), out_bit, b);
            tick();
        end
        check("fresh_done_valid", out_valid, 0);

        // ---- randomized run against the reference model ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        model_l = SEED_D;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic exp_v, exp_b, exp_l;
            bit   was_empty;
            exp_v = (exp_q.size() != 0);
            exp_b = exp_v ? exp_q[0] : 1'b0;
            exp_l = (exp_q.size() == 1);
            tests_run++;
            if (lfsr_state !== model_l || out_valid !== exp_v || out_bit !== exp_b ||
                out_last !== exp_l || busy !== exp_v) begin
                tests_failed++;
                $display("FAIL rand_cycle%0d: got st=%h v=%b b=%b l=%b busy=%b expected st=%h v=%b b=%b l=%b busy=%b",
                         cyc, lfsr_state, out_valid, out_bit, out_last, busy,
                         model_l, exp_v, exp_b, exp_l, exp_v);
            end
            seed_load  = ($urandom_range(0, 9) == 0);
            seed       = 8'($urandom);
            enable     = ($urandom_range(0, 3) != 0);
            out_enable = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            was_empty = (exp_q.size() == 0);
            if (!was_empty && out_ready) void'(exp_q.pop_front());
            if (was_empty && out_enable) push_word(model_l);
            if (seed_load) model_l = seed;
            else if (enable) model_l = ref_step(model_l, 1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
